// File: rtl/command_pkg.sv
// rtl/command_pkg.sv - shared types, ASCII constants and command table for command frames
package command_pkg;

    // Frame format shared with the command-to-JSON translator.
    localparam int DEF_MAX_LEN     = 32;
    localparam int DEF_FRAC_DIGITS = 2;
    localparam int FIELD_COUNT     = 3;
    localparam int ACC_W           = 17;

    localparam int CMD_W     = 3;
    localparam int CMD_COUNT = 2;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_KEY_Q1,
        ST_KEY,
        ST_KEY_Q2,
        ST_COLON,
        ST_NUM_SIGN,
        ST_NUM_INT,
        ST_NUM_FRAC
    } parse_state_t;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    // Key letter expected for field index 0, 1, 2.
    localparam logic [7:0] KEY_CHARS [FIELD_COUNT] = '{8'h54, 8'h4C, 8'h52};

    typedef struct packed {
        logic [7:0]  t;
        logic [15:0] l;
        logic [15:0] r;
    } cmd_entry_t;

    // Indexed by command code; L/R in hundredths.
    localparam cmd_entry_t CMD_TABLE [CMD_COUNT] = '{
        '{t: 8'd1, l: 16'd50, r: 16'd50},
        '{t: 8'd0, l: 16'd0,  r: 16'd0}
    };

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < 9; i++) begin
            if (i < n) p = p * 32'd10;
        end
        return p;
    endfunction

    // Returns {known, code}; code is 0 when no entry matches.
    function automatic logic [CMD_W:0] cmd_lookup(input logic [7:0] t,
                                                  input logic [15:0] l,
                                                  input logic [15:0] r);
        logic [CMD_W:0] res;
        res = '0;
        for (int i = CMD_COUNT - 1; i >= 0; i--) begin
            if (CMD_TABLE[i].t == t && CMD_TABLE[i].l == l && CMD_TABLE[i].r == r)
                res = {1'b1, CMD_W'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// rtl/decimal_accumulator.sv - decimal digit accumulator with fraction scaling and sign
// Ports: clk, rst_n; clear/digit_en/digit/point_en/neg_en controls;
//        raw (unscaled magnitude), frac_cnt, negative, overflow (sticky),
//        magnitude (scaled by 10^(FRAC_DIGITS-frac_cnt)), value (signed 16-bit).
module decimal_accumulator import command_pkg::*; #(
    parameter int FRAC_DIGITS = DEF_FRAC_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             digit_en,
    input  logic [3:0]       digit,
    input  logic             point_en,
    input  logic             neg_en,
    output logic [ACC_W-1:0] raw,
    output logic [3:0]       frac_cnt,
    output logic             negative,
    output logic             overflow,
    output logic [31:0]      magnitude,
    output logic [15:0]      value
);

    logic             point_seen;
    logic [ACC_W+3:0] next_acc;

    assign next_acc = {4'd0, raw} * (ACC_W + 4)'(10) + (ACC_W + 4)'(digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw        <= '0;
            frac_cnt   <= '0;
            negative   <= 1'b0;
            overflow   <= 1'b0;
            point_seen <= 1'b0;
        end else if (clear) begin
            raw        <= '0;
            frac_cnt   <= '0;
            negative   <= 1'b0;
            overflow   <= 1'b0;
            point_seen <= 1'b0;
        end else begin
            if (digit_en) begin
                // Once the 17-bit accumulator wraps the number is unusable; keep it flagged.
                if (next_acc[ACC_W+3:ACC_W] != '0) overflow <= 1'b1;
                raw <= next_acc[ACC_W-1:0];
                if (point_seen) frac_cnt <= frac_cnt + 4'd1;
            end
            if (point_en) point_seen <= 1'b1;
            if (neg_en)   negative   <= 1'b1;
        end
    end

    // Missing fractional digits are made up by scaling, so 0.5 and 0.50 agree.
    assign magnitude = 32'(raw) * pow10(FRAC_DIGITS - int'(frac_cnt));
    assign value     = negative ? (16'd0 - magnitude[15:0]) : magnitude[15:0];

endmodule

// File: rtl/command_parser.sv
// rtl/command_parser.sv - parses {"T":<int>,"L":<dec>,"R":<dec>} byte frames into fixed-point fields
// Ports: clk, rst_n; byte input in_byte/in_valid/in_ready;
//        decoded t_val, l_val, r_val, cmd, cmd_known held with out_valid until out_ready;
//        frame_error one-cycle pulse on a malformed frame.
module command_parser import command_pkg::*; #(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int FRAC_DIGITS = DEF_FRAC_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       t_val,
    output logic [15:0]      l_val,
    output logic [15:0]      r_val,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_known,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_error
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    parse_state_t     state;
    parse_state_t     nxt_state;
    logic [1:0]       field;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       t_hold;
    logic [15:0]      l_hold;

    logic xfer, is_ws, is_digit, end_byte, range_bad;
    logic bad, num_end, sep_comma, sep_close;
    logic acc_clear, acc_digit, acc_point, acc_neg;

    logic [ACC_W-1:0] acc_raw;
    logic [3:0]       acc_frac;
    logic             acc_negative;
    logic             acc_ovf;
    logic [31:0]      acc_mag;
    logic [15:0]      acc_value;
    logic [CMD_W:0]   lookup;

    decimal_accumulator #(.FRAC_DIGITS(FRAC_DIGITS)) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (acc_clear),
        .digit_en  (acc_digit),
        .digit     (in_byte[3:0]),
        .point_en  (acc_point),
        .neg_en    (acc_neg),
        .raw       (acc_raw),
        .frac_cnt  (acc_frac),
        .negative  (acc_negative),
        .overflow  (acc_ovf),
        .magnitude (acc_mag),
        .value     (acc_value)
    );

    assign in_ready  = !out_valid;
    assign xfer      = in_valid && in_ready;
    assign is_ws     = (in_byte == CH_SPACE) || (in_byte == CH_CR) || (in_byte == CH_LF);
    assign is_digit  = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign end_byte  = (in_byte == CH_COMMA) || (in_byte == CH_RBRACE);
    // T is an unscaled integer; L/R are checked after fraction scaling.
    assign range_bad = acc_ovf || ((field == 2'd0) ? (acc_raw > ACC_W'(255))
                                                   : (acc_mag > 32'd32767));
    // R is still in the accumulator when '}' arrives.
    assign lookup    = cmd_lookup(t_hold, l_hold, acc_value);

    always_comb begin
        nxt_state = state;
        bad       = 1'b0;
        num_end   = 1'b0;
        sep_comma = 1'b0;
        sep_close = 1'b0;
        acc_clear = 1'b0;
        acc_digit = 1'b0;
        acc_point = 1'b0;
        acc_neg   = 1'b0;
        if (xfer) begin
            // A '{' inside a frame or a byte beyond MAX_LEN aborts the frame.
            if (state != ST_HUNT && (in_byte == CH_LBRACE || byte_cnt == CNT_W'(MAX_LEN))) begin
                bad = 1'b1;
            end else begin
                unique case (state)
                    ST_HUNT: begin
                        if (in_byte == CH_LBRACE) nxt_state = ST_KEY_Q1;
                    end
                    ST_KEY_Q1: begin
                        if (in_byte == CH_QUOTE) nxt_state = ST_KEY;
                        else if (!is_ws)         bad = 1'b1;
                    end
                    ST_KEY: begin
                        if (in_byte == KEY_CHARS[field]) nxt_state = ST_KEY_Q2;
                        else if (!is_ws)                 bad = 1'b1;
                    end
                    ST_KEY_Q2: begin
                        if (in_byte == CH_QUOTE) nxt_state = ST_COLON;
                        else if (!is_ws)         bad = 1'b1;
                    end
                    ST_COLON: begin
                        if (in_byte == CH_COLON) begin
                            nxt_state = ST_NUM_SIGN;
                            acc_clear = 1'b1;
                        end else if (!is_ws) begin
                            bad = 1'b1;
                        end
                    end
                    ST_NUM_SIGN: begin
                        if (in_byte == CH_MINUS && field != 2'd0 && !acc_negative) begin
                            acc_neg = 1'b1;
                        end else if (is_digit) begin
                            acc_digit = 1'b1;
                            nxt_state = ST_NUM_INT;
                        end else if (!is_ws) begin
                            bad = 1'b1;
                        end
                    end
                    ST_NUM_INT: begin
                        if (is_digit) begin
                            acc_digit = 1'b1;
                        end else if (in_byte == CH_DOT && field != 2'd0) begin
                            acc_point = 1'b1;
                            nxt_state = ST_NUM_FRAC;
                        end else if (end_byte) begin
                            num_end = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    ST_NUM_FRAC: begin
                        if (is_digit && acc_frac < 4'(FRAC_DIGITS)) begin
                            acc_digit = 1'b1;
                        end else if (end_byte && acc_frac != 4'd0) begin
                            num_end = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: nxt_state = ST_HUNT;
                endcase

                if (num_end) begin
                    if (range_bad) begin
                        bad = 1'b1;
                    end else if (in_byte == CH_COMMA && field != 2'd2) begin
                        sep_comma = 1'b1;
                        nxt_state = ST_KEY_Q1;
                    end else if (in_byte == CH_RBRACE && field == 2'd2) begin
                        sep_close = 1'b1;
                        nxt_state = ST_HUNT;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HUNT;
            field       <= '0;
            byte_cnt    <= '0;
            t_hold      <= '0;
            l_hold      <= '0;
            t_val       <= '0;
            l_val       <= '0;
            r_val       <= '0;
            cmd         <= '0;
            cmd_known   <= 1'b0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (xfer) begin
                if (bad) begin
                    frame_error <= 1'b1;
                    field       <= '0;
                    byte_cnt    <= CNT_W'(1);
                    // An offending '{' is also the start of the next frame.
                    state       <= (in_byte == CH_LBRACE) ? ST_KEY_Q1 : ST_HUNT;
                end else begin
                    state <= nxt_state;
                    if (state == ST_HUNT) begin
                        field    <= '0;
                        byte_cnt <= CNT_W'(1);
                    end else begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end
                    if (sep_comma) begin
                        if (field == 2'd0) t_hold <= acc_raw[7:0];
                        else               l_hold <= acc_value;
                        field <= field + 2'd1;
                    end
                    if (sep_close) begin
                        t_val     <= t_hold;
                        l_val     <= l_hold;
                        r_val     <= acc_value;
                        cmd       <= lookup[CMD_W-1:0];
                        cmd_known <= lookup[CMD_W];
                        out_valid <= 1'b1;
                        field     <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/command_parser.md
Name: command_parser

Overview:
- Receive-side counterpart of the command-to-JSON translator.
- Consumes an ASCII byte stream from the UART RX path, one byte per handshake, and parses frames of the form {"T":<int>,"L":<dec>,"R":<dec>}.
- Outputs the decoded fields in fixed point and maps recognised value sets back to a 3-bit command code.
- Sits between the UART byte receiver and the controller status logic.

Parameters:
- MAX_LEN, 32, maximum bytes from '{' to '}' inclusive; longer frames are an error.
- FRAC_DIGITS, 2, maximum fractional digits accepted. L/R are scaled by 10^FRAC_DIGITS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_byte  in  8  ASCII byte from the receiver
- in_valid  in  1  in_byte valid
- in_ready  out  1  parser can accept in_byte
- t_val  out  8  decoded T, unsigned integer
- l_val  out  16  decoded L, signed, hundredths (0.5 -> 50)
- r_val  out  16  decoded R, signed, hundredths
- cmd  out  3  command code matching (t,l,r); valid only when cmd_known=1
- cmd_known  out  1  decoded values match an entry of the command table
- out_valid  out  1  decoded frame held on outputs
- out_ready  in  1  consumer accepts decoded frame
- frame_error  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset is asynchronous, active-low, and applies to the whole block:
  - All outputs go to 0 except in_ready, which is 1.
  - State goes to HUNT.
- Byte transfer occurs when in_valid & in_ready.
- in_ready = !out_valid. While a decoded frame is pending, no bytes are accepted.
- States:
  - HUNT: wait for '{'; all other bytes are discarded silently.
  - KEY_Q1: expect '"'.
  - KEY: expect the key letter for the current field index (0:'T', 1:'L', 2:'R').
  - KEY_Q2: expect '"'.
  - COLON: expect ':'.
  - NUM_SIGN: optional '-' (field 0 forbids '-'), else the first digit.
  - NUM_INT: digits; '.' goes to NUM_FRAC; ',' or '}' ends the number.
  - NUM_FRAC: 1..FRAC_DIGITS digits, then ',' or '}'.
  - A number with no integer digit is an error; '.' with zero fractional digits is an error.
- Separator rules:
  - ',' is legal only for field index 0 or 1, and moves to KEY_Q1 for the next field.
  - '}' is legal only for field index 2.
- Spaces, CR and LF are ignored in every state except NUM_INT and NUM_FRAC, where they are an error.
- Value arithmetic:
  - Accumulate magnitude as acc*10 + digit in 17 bits.
  - Scale by 10^(FRAC_DIGITS - frac_digits_seen) at the number end.
  - Apply the sign last.
  - Error if T > 255, or if L/R magnitude > 32767.
- Accepting a valid '}':
  - Next cycle, latch t_val/l_val/r_val, cmd and cmd_known, and raise out_valid.
  - Latency is 1 cycle from the '}' transfer to out_valid.
  - Return to HUNT.
- out_valid holds and outputs stay stable until out_ready is sampled high; out_valid clears on the following edge.
- Command table (package): (1,50,50) -> cmd 0; (0,0,0) -> cmd 1. Any other combination gives cmd_known=0 and cmd=0.
- Error handling: any illegal byte, number overflow, or byte count > MAX_LEN:
  - frame_error pulses high for 1 cycle after the offending transfer.
  - Partial fields are discarded; outputs keep their previous values.
  - State goes to HUNT.
  - If the offending byte is itself '{', it goes to KEY_Q1 instead (resync).
- '{' received mid-frame in any non-HUNT state counts as an error plus a restart, with the same pulse.
- Reset mid-frame discards everything; no error pulse.

Decomposition:
- Package command_pkg holds:
  - the parser state enum;
  - ASCII constants ('{', '}', '"', ':', ',', '.', '-');
  - the key letters array;
  - the command table as a localparam array of {t,l,r} per code, plus CMD_W=3;
  - the shared frame format constants used by the translator.
- One natural sub-module: decimal_accumulator. It owns the digit/fraction counters, the overflow flag, and the scaled signed result, with clear/digit/finish controls.

Test Plan:
- Stream "{\"T\":1,\"L\":0.5,\"R\":0.5}" with out_ready=1 -> one cycle after '}': out_valid=1, t_val=1, l_val=50, r_val=50, cmd=0, cmd_known=1, frame_error never high.
- Stream "{\"T\":0,\"L\":0.0,\"R\":0.0}" with out_ready=0 for 5 cycles -> out_valid stays 1, in_ready=0, outputs hold cmd=1; deassert after out_ready.
- Stream "{\"T\":2,\"L\":-1.25,\"R\":3}" -> t_val=2, l_val=-125 (0xFF83), r_val=300, cmd_known=0.
- Stream "{\"T\":1,\"X\"..." then a valid frame -> frame_error pulse exactly once, bytes ignored until next '{', second frame decoded correctly.
- Edge values:
  - "{\"T\":256,...}" -> frame_error.
  - "L\":327.67" -> l_val=32767, accepted.
  - "L\":0.125" -> frame_error (3 fractional digits).
- Assert rst_n low after "{\"T\":1," then release and send a full frame -> all outputs 0 during reset, no error pulse, frame decodes normally.
